// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution: branch classes, conditional funct3 codes
// and the one-hot branch_type decision constants.
package branch_pkg;

    typedef enum logic [2:0] {
        BC_NONE = 3'b000,
        BC_COND = 3'b001,
        BC_JAL  = 3'b010,
        BC_JALR = 3'b100
    } branch_class_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_func3_e;

    localparam logic [3:0] BT_NONE    = 4'b0000;
    localparam logic [3:0] BT_COND    = 4'b0001;
    localparam logic [3:0] BT_JAL     = 4'b0010;
    localparam logic [3:0] BT_JALR    = 4'b0100;
    localparam logic [3:0] BT_ILLEGAL = 4'b1000;

    // A decision redirects the fetch stream when it is a taken branch or a jump.
    function automatic logic is_redirect(input logic [3:0] bt);
        return (bt == BT_COND) || (bt == BT_JAL) || (bt == BT_JALR);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// XLEN-wide operand comparator: equality, two's-complement less-than and
// magnitude less-than, all evaluated at exactly XLEN bits.
module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_eq,
    output logic            o_lt,
    output logic            o_ltu
);

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;

    assign w_a_s = $signed(i_a);
    assign w_b_s = $signed(i_b);

    assign o_eq  = (i_a == i_b);
    assign o_lt  = (w_a_s < w_b_s);
    assign o_ltu = (i_a < i_b);

endmodule

// File: rtl/branch_control.sv
// Branch resolution: combinational decision registered onto one-hot branch_type.
// Optional redirect counter taken_cnt is built only when BRANCH_TAKEN_CNT_EN is defined.
module branch_control
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      BranchControl,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [2:0]      func3,
    output logic [3:0]      branch_type
`ifdef BRANCH_TAKEN_CNT_EN
    ,
    output logic [31:0]     taken_cnt
`endif
);

    logic       w_eq;
    logic       w_lt;
    logic       w_ltu;
    logic [3:0] w_decision_p0;
    logic [3:0] r_branch_type_p1;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .i_a   (data1),
        .i_b   (data2),
        .o_eq  (w_eq),
        .o_lt  (w_lt),
        .o_ltu (w_ltu)
    );

    // Stage p0: combinational decision from class, funct3 and comparator flags.
    always_comb begin
        w_decision_p0 = BT_NONE;
        case (BranchControl)
            BC_NONE: w_decision_p0 = BT_NONE;
            BC_COND: begin
                case (func3)
                    F3_BEQ:  w_decision_p0 = w_eq   ? BT_COND : BT_NONE;
                    F3_BNE:  w_decision_p0 = !w_eq  ? BT_COND : BT_NONE;
                    F3_BLT:  w_decision_p0 = w_lt   ? BT_COND : BT_NONE;
                    F3_BGE:  w_decision_p0 = !w_lt  ? BT_COND : BT_NONE;
                    F3_BLTU: w_decision_p0 = w_ltu  ? BT_COND : BT_NONE;
                    F3_BGEU: w_decision_p0 = !w_ltu ? BT_COND : BT_NONE;
                    default: w_decision_p0 = BT_ILLEGAL;
                endcase
            end
            BC_JAL:  w_decision_p0 = BT_JAL;
            BC_JALR: w_decision_p0 = BT_JALR;
            default: w_decision_p0 = BT_ILLEGAL;
        endcase
    end

    // Stage p1: registered decision; reset drops any decision still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_type_p1 <= BT_NONE;
        end else begin
            r_branch_type_p1 <= w_decision_p0;
        end
    end

    assign branch_type = r_branch_type_p1;

`ifdef BRANCH_TAKEN_CNT_EN
    logic [31:0] r_taken_cnt;

    // Counts on the same edge that loads a redirecting decision; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= 32'd0;
        end else if (is_redirect(w_decision_p0)) begin
            r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign taken_cnt = r_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_control.sv
// Directed and randomized bench for branch_control with a scoreboard queue of
// expected branch_type values; counter checks build when BRANCH_TAKEN_CNT_EN is defined.
module tb_branch_control;

    logic        clk;
    logic        rst_n;
    logic [2:0]  BranchControl;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  func3;
    logic [3:0]  branch_type;
`ifdef BRANCH_TAKEN_CNT_EN
    logic [31:0] taken_cnt;
`endif

    int n_assert;
    int n_fail;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    branch_control #(
        .XLEN (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .BranchControl (BranchControl),
        .data1         (data1),
        .data2         (data2),
        .func3         (func3),
        .branch_type   (branch_type)
`ifdef BRANCH_TAKEN_CNT_EN
        ,
        .taken_cnt     (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference for the registered decision.
    function automatic logic [3:0] model(input logic [2:0] bc, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               c;
        sa = a;
        sb = b;
        case (bc)
            3'b000: return 4'b0000;
            3'b010: return 4'b0010;
            3'b100: return 4'b0100;
            3'b001: begin
                case (f3)
                    3'b000:  c = (a == b);
                    3'b001:  c = (a != b);
                    3'b100:  c = (sa < sb);
                    3'b101:  c = (sa >= sb);
                    3'b110:  c = (a < b);
                    3'b111:  c = (a >= b);
                    default: return 4'b1000;
                endcase
                return c ? 4'b0001 : 4'b0000;
            end
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check_now(input string tag, input logic [3:0] exp);
        n_assert++;
        assert (branch_type === exp)
        else begin
            n_fail++;
            $error("FAIL %s: branch_type=%b expected=%b", tag, branch_type, exp);
        end
    endtask

    // Pops the oldest expectation once the DUT has registered a decision.
    task automatic check_pop();
        logic [3:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed=%b expected=<none>", branch_type);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_now(t, e);
            n_assert++;
            assert ($onehot0(branch_type))
            else begin
                n_fail++;
                $error("FAIL %s_onehot: branch_type=%b expected=one-hot or zero", t, branch_type);
            end
        end
    endtask

    task automatic apply(input string tag, input logic [2:0] bc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] exp);
        @(negedge clk);
        BranchControl = bc;
        func3         = f3;
        data1         = a;
        data2         = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef BRANCH_TAKEN_CNT_EN
        n_assert++;
        assert (taken_cnt === exp)
        else begin
            n_fail++;
            $error("FAIL %s: taken_cnt=%h expected=%h", tag, taken_cnt, exp);
        end
`else
        if (tag.len() == 0 && exp == 32'd0) begin
            n_assert += 0;
        end
`endif
    endtask

    initial begin
        logic [2:0] f3_sweep [5];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        n_assert = 0;
        n_fail   = 0;
        f3_sweep = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110};

        // Reset held with a JAL pending: output stays zero, even across edges.
        rst_n         = 1'b0;
        BranchControl = 3'b010;
        func3         = 3'b000;
        data1         = 32'd0;
        data2         = 32'd0;
        #1;
        check_now("reset_immediate", 4'b0000);
        @(posedge clk);
        #1;
        check_now("reset_held_edge", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'b0010);
        tag_q.push_back("reset_release_jal");
        @(posedge clk);
        #1;
        check_pop();

        // Asynchronous assertion mid-operation discards the pending JALR.
        @(negedge clk);
        BranchControl = 3'b100;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_async_mid", 4'b0000);
        @(posedge clk);
        #1;
        check_now("reset_discard", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'b0100);
        tag_q.push_back("release_first_edge");
        @(posedge clk);
        #1;
        check_pop();

        apply("beq_eq",        3'b001, 3'b000, 32'd1, 32'd1, 4'b0001);
        apply("beq_ne",        3'b001, 3'b000, 32'd1, 32'd2, 4'b0000);
        apply("bne_ne",        3'b001, 3'b001, 32'd1, 32'd2, 4'b0001);
        apply("bne_eq",        3'b001, 3'b001, 32'd5, 32'd5, 4'b0000);
        apply("blt_neg",       3'b001, 3'b100, 32'hFFFF_FFFF, 32'd1, 4'b0001);
        apply("bltu_big",      3'b001, 3'b110, 32'hFFFF_FFFF, 32'd1, 4'b0000);
        apply("bge_neg",       3'b001, 3'b101, 32'hFFFF_FFFF, 32'd1, 4'b0000);
        apply("bgeu_big",      3'b001, 3'b111, 32'hFFFF_FFFF, 32'd1, 4'b0001);
        apply("bge_gt",        3'b001, 3'b101, 32'd3, 32'd2, 4'b0001);
        apply("blt_gt",        3'b001, 3'b100, 32'd3, 32'd2, 4'b0000);
        apply("bgeu_gt",       3'b001, 3'b111, 32'd7, 32'd6, 4'b0001);
        apply("illegal_f3_010", 3'b001, 3'b010, 32'd7, 32'd6, 4'b1000);
        apply("illegal_f3_011", 3'b001, 3'b011, 32'd7, 32'd6, 4'b1000);
        apply("bge_equal",     3'b001, 3'b101, 32'd5, 32'd5, 4'b0001);
        apply("bgeu_equal",    3'b001, 3'b111, 32'd5, 32'd5, 4'b0001);
        apply("blt_equal",     3'b001, 3'b100, 32'd5, 32'd5, 4'b0000);
        apply("bltu_equal",    3'b001, 3'b110, 32'd5, 32'd5, 4'b0000);
        apply("blt_minmax",    3'b001, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0001);
        apply("bltu_minmax",   3'b001, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0000);

        for (int i = 0; i < 5; i++) begin
            apply($sformatf("jal_f3_%0d", i), 3'b010, f3_sweep[i], $urandom, $urandom, 4'b0010);
        end
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("jalr_f3_%0d", i), 3'b100, f3_sweep[i], $urandom, $urandom, 4'b0100);
        end
        apply("none",     3'b000, 3'b000, 32'd1, 32'd1, 4'b0000);
        apply("bc_011",   3'b011, 3'b000, 32'd1, 32'd1, 4'b1000);
        apply("bc_101",   3'b101, 3'b001, 32'd1, 32'd2, 4'b1000);
        apply("bc_110",   3'b110, 3'b100, 32'd1, 32'd2, 4'b1000);
        apply("bc_111",   3'b111, 3'b111, 32'd1, 32'd2, 4'b1000);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            if (i % 3 == 0) rb[31] = ~ra[31];
            rf = 3'($urandom_range(0, 7));
            apply($sformatf("rand_cond_%0d", i), 3'b001, rf, ra, rb, model(3'b001, rf, ra, rb));
        end

`ifdef BRANCH_TAKEN_CNT_EN
        @(negedge clk);
        BranchControl = 3'b000;
        rst_n = 1'b0;
        #1;
        check_cnt("cnt_reset", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("cnt_t1", 3'b001, 3'b000, 32'd4, 32'd4, 4'b0001);
        apply("cnt_n1", 3'b001, 3'b001, 32'd4, 32'd4, 4'b0000);
        apply("cnt_t2", 3'b010, 3'b000, 32'd0, 32'd0, 4'b0010);
        apply("cnt_n2", 3'b000, 3'b000, 32'd0, 32'd0, 4'b0000);
        apply("cnt_il", 3'b011, 3'b000, 32'd0, 32'd0, 4'b1000);
        apply("cnt_t3", 3'b100, 3'b000, 32'd0, 32'd0, 4'b0100);
        check_cnt("cnt_three", 32'd3);
        @(negedge clk);
        BranchControl = 3'b000;
        force dut.r_taken_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_taken_cnt;
        apply("cnt_wrap_jal", 3'b010, 3'b000, 32'd0, 32'd0, 4'b0010);
        check_cnt("cnt_wrap", 32'd0);
`endif

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_control.md
BRANCH_CONTROL -- requirements
Module: branch_control

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 BranchControl  input  3  one-hot branch class: 001 conditional (B-type), 010 JAL, 100 JALR, 000 no branch.
REQ-005 data1  input  XLEN  rs1 operand.
REQ-006 data2  input  XLEN  rs2 operand.
REQ-007 func3  input  3  instruction funct3 field; meaningful only for the conditional class.
REQ-008 branch_type  output  4  registered one-hot decision: 0000 none or not taken, 0001 conditional taken, 0010 JAL, 0100 JALR, 1000 illegal.
REQ-009 taken_cnt  output  32  count of redirecting decisions; present only under BRANCH_TAKEN_CNT_EN.

Function
REQ-010 Decision logic SHALL be combinational; branch_type SHALL be that decision registered, so it appears on the first rising clk edge after inputs are applied (latency 1 cycle).
REQ-011 BranchControl=001: func3 000 BEQ (data1==data2), 001 BNE (!=), 100 BLT (signed <), 101 BGE (signed >=), 110 BLTU (unsigned <), 111 BGEU (unsigned >=); condition true -> 0001, false -> 0000.
REQ-012 BranchControl=001 with func3 010 or 011 SHALL yield 1000.
REQ-013 BranchControl=010 SHALL yield 0010 regardless of func3, data1 and data2.
REQ-014 BranchControl=100 SHALL yield 0100 regardless of func3, data1 and data2.
REQ-015 BranchControl=000 SHALL yield 0000.
REQ-016 Any non-one-hot nonzero BranchControl (011, 101, 110, 111) SHALL yield 1000.
REQ-017 Signed comparisons SHALL use two's-complement at XLEN bits; unsigned comparisons SHALL treat operands as magnitudes; no wider extension is permitted.
REQ-018 branch_type SHALL be exactly one-hot or all-zero in every cycle.

Reset
REQ-019 While rst_n=0, branch_type SHALL be 0000 and taken_cnt SHALL be 0, immediately and independently of clk.
REQ-020 On rst_n deassertion, the first rising clk edge SHALL register the current decision; reset asserted mid-operation SHALL discard the pending decision.

Configuration
REQ-021 Macro BRANCH_TAKEN_CNT_EN defined: taken_cnt port exists and increments by 1 on each clk edge where the registered branch_type becomes 0001, 0010 or 0100; it wraps from 0xFFFFFFFF to 0.
REQ-022 Macro BRANCH_TAKEN_CNT_EN undefined: taken_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-023 A shared package branch_pkg SHALL hold the BranchControl class encodings, the func3 codes BEQ, BNE, BLT, BGE, BLTU and BGEU, and the four branch_type one-hot constants.
REQ-024 A sub-module branch_cmp SHALL implement the XLEN-wide eq, signed-lt and unsigned-lt comparisons; branch_control SHALL instantiate it once.

Verification
REQ-025 Reset: rst_n=0 with BranchControl=010 -> branch_type=0000 immediately; after release, one edge later -> 0010.
REQ-026 Conditional, data1=1, data2=1: func3=000 -> 0001; with data2=2, func3=000 -> 0000 and func3=001 -> 0001.
REQ-027 Conditional signed versus unsigned, data1=0xFFFFFFFF, data2=1: func3=100 -> 0001, 110 -> 0000, 101 -> 0000, 111 -> 0001.
REQ-028 Conditional with data1=3, data2=2: func3=101 -> 0001 and func3=100 -> 0000; with data1=7, data2=6, func3=111 -> 0001; func3=010 -> 1000.
REQ-029 BranchControl=010 and then 100, each swept across func3 000, 001, 100, 101, 110 -> constantly 0010 and 0100 respectively; BranchControl=000 -> 0000; BranchControl=011 -> 1000.
REQ-030 With BRANCH_TAKEN_CNT_EN defined, apply 3 taken decisions, 2 not-taken decisions and 1 illegal decision -> taken_cnt=3; preload the counter to 0xFFFFFFFF and apply one taken decision -> taken_cnt=0.
